// File: rtl/conv_ctrl_pkg.sv
// ============================================================================
// conv_ctrl_pkg : state encoding and shared constants for the conv row sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package conv_ctrl_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam logic [2:0] S_FLUSH  = 3'd5;
    localparam logic [2:0] S_DRAIN  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    // Registered read of the last psum FIFO during drain
    localparam int DRAIN_RD_LAT = 1;

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/en_delay_line.sv
// ============================================================================
// en_delay_line : shift register carrying FIFO enable tags from the ifm handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module en_delay_line #(
    parameter int DEPTH  = 1,
    parameter int WIDTH  = 4,
    parameter int RD_DLY = 0
) (
    input  logic             clk2,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rd_tap,
    output logic [WIDTH-1:0] wr_tap,
    output logic             occupied
);

    logic [WIDTH-1:0] stage [DEPTH];
    logic [DEPTH-1:0] stage_nz;

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // Empty slots carry an all-zero word, so any set bit marks a live tag
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_nz
            assign stage_nz[i] = |stage[i];
        end

        if (RD_DLY == 0) begin : g_rd_direct
            assign rd_tap = din;
        end else begin : g_rd_stage
            assign rd_tap = stage[RD_DLY-1];
        end
    endgenerate

    assign wr_tap   = stage[DEPTH-1];
    assign occupied = |stage_nz;

endmodule

`default_nettype wire

// File: rtl/conv_row_sequencer.sv
// ============================================================================
// conv_row_sequencer : FSM driving weight/ifm loads and psum FIFO chaining.
// Optional macro PERF_CNT_EN enables the handshake-stall counter.   Rev 1.0
// ============================================================================
`default_nettype none

module conv_row_sequencer
    import conv_ctrl_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int FIFO_SIZE   = 10,
    parameter int COL_W       = 8,
    parameter int ROW_W       = 8,
    parameter int PE_LAT      = 1
) (
    input  logic                   clk2,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [COL_W-1:0]       cfg_cols,
    input  logic [ROW_W-1:0]       cfg_out_rows,
    input  logic                   ifm_valid,
    output logic                   ifm_ready,
    output logic                   set_ifm,
    output logic                   set_wgt,
    output logic                   fifo_clr,
    output logic [KERNEL_SIZE-1:0] fifo_wr_en,
    output logic [KERNEL_SIZE-1:0] fifo_rd_en,
    output logic                   psum_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err,
    output logic [15:0]            stall_cycles
);

    localparam int KW = clog2_min1(KERNEL_SIZE);
    localparam int TW = KW + 2;
    localparam logic [COL_W-1:0] KM1_C    = COL_W'(KERNEL_SIZE - 1);
    localparam logic [KW-1:0]    KM1_K    = KW'(KERNEL_SIZE - 1);
    localparam logic [31:0]      MIN_COLS = 32'(KERNEL_SIZE);
    localparam logic [31:0]      MAX_COLS = 32'(FIFO_SIZE + KERNEL_SIZE - 1);

    logic [2:0]              state;
    logic [COL_W-1:0]        cols_q;
    logic [COL_W-1:0]        n_q;
    logic [COL_W-1:0]        col;
    logic [COL_W-1:0]        drain_cnt;
    logic [ROW_W-1:0]        rows_q;
    logic [ROW_W-1:0]        out_row;
    logic [KW-1:0]           k;
    logic [DRAIN_RD_LAT-1:0] psum_pipe;

    logic          handshake;
    logic          cfg_bad;
    logic          start_ok;
    logic          last_col;
    logic          drain_last;
    logic          line_busy;
    logic [TW-1:0] tag_in;
    logic [TW-1:0] rd_tap;
    logic [TW-1:0] wr_tap;
    logic          unused_tag_bits;

    assign ifm_ready  = (state == S_STREAM);
    assign handshake  = ifm_valid & ifm_ready;
    assign set_ifm    = handshake;
    assign set_wgt    = (state == S_LOAD);
    assign fifo_clr   = (state == S_CLEAR);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign psum_valid = psum_pipe[DRAIN_RD_LAT-1];

    // Legal only when 1 <= windows-per-row <= FIFO depth
    assign cfg_bad    = (32'(cfg_cols) < MIN_COLS) || (32'(cfg_cols) > MAX_COLS);
    assign start_ok   = (state == S_IDLE) && start && !cfg_bad;
    assign last_col   = (col == cols_q - 1'b1);
    assign drain_last = (drain_cnt == n_q - 1'b1);

    // Tag word {wr, rd, k}; zero when the handshake produces no window
    assign tag_in = (handshake && (col >= KM1_C)) ? {1'b1, (k != '0), k} : '0;

    en_delay_line #(
        .DEPTH  (PE_LAT),
        .WIDTH  (TW),
        .RD_DLY (PE_LAT - 1)
    ) u_en_delay_line (
        .clk2     (clk2),
        .rst_n    (rst_n),
        .din      (tag_in),
        .rd_tap   (rd_tap),
        .wr_tap   (wr_tap),
        .occupied (line_busy)
    );

    assign unused_tag_bits = rd_tap[TW-1] ^ wr_tap[TW-2];

    generate
        for (genvar i = 0; i < KERNEL_SIZE; i++) begin : g_fifo_en
            assign fifo_wr_en[i] = wr_tap[TW-1] && (wr_tap[KW-1:0] == KW'(i));
            if (i < KERNEL_SIZE - 1) begin : g_chain_rd
                assign fifo_rd_en[i] = rd_tap[TW-2] && (rd_tap[KW-1:0] == KW'(i + 1));
            end else begin : g_drain_rd
                assign fifo_rd_en[i] = (state == S_DRAIN);
            end
        end
    endgenerate

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cols_q    <= '0;
            n_q       <= '0;
            rows_q    <= '0;
            out_row   <= '0;
            col       <= '0;
            drain_cnt <= '0;
            k         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        cols_q  <= cfg_cols;
                        n_q     <= cfg_cols - KM1_C;
                        rows_q  <= cfg_out_rows;
                        out_row <= '0;
                        state   <= (cfg_out_rows == '0) ? S_DONE : S_CLEAR;
                    end
                end
                S_CLEAR: state <= S_LOAD;
                S_LOAD: begin
                    k         <= '0;
                    col       <= '0;
                    drain_cnt <= '0;
                    state     <= S_STREAM;
                end
                S_STREAM: begin
                    if (handshake) begin
                        if (last_col) begin
                            col   <= '0;
                            state <= S_GAP;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (k < KM1_K) begin
                        k     <= k + 1'b1;
                        state <= S_STREAM;
                    end else begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (!line_busy) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_last) begin
                        drain_cnt <= '0;
                        out_row   <= out_row + 1'b1;
                        state     <= (out_row + 1'b1 < rows_q) ? S_CLEAR : S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sticky until the next start decision in IDLE
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else if ((state == S_IDLE) && start) begin
            cfg_err <= cfg_bad;
        end
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            psum_pipe <= '0;
        end else begin
            psum_pipe <= DRAIN_RD_LAT'({psum_pipe, (state == S_DRAIN)});
        end
    end

`ifdef PERF_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (start_ok) begin
            stall_q <= '0;
        end else if ((state == S_STREAM) && !ifm_valid && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv_row_sequencer.sv
// ============================================================================
// tb_conv_row_sequencer : directed self-checking bench for conv_row_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_conv_row_sequencer;

    logic        clk2 = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  cfg_cols;
    logic [7:0]  cfg_out_rows;
    logic        ifm_valid;
    logic        ifm_ready;
    logic        set_ifm;
    logic        set_wgt;
    logic        fifo_clr;
    logic [2:0]  fifo_wr_en;
    logic [2:0]  fifo_rd_en;
    logic        psum_valid;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic [15:0] stall_cycles;

    int compared   = 0;
    int mismatched = 0;

    int n_clr, n_wgt, n_ifm, n_psum, n_done, n_busy, n_order_err;
    int n_wr [3];
    int n_rd [3];
    logic prev_rd0;

`ifdef PERF_CNT_EN
    localparam int STALL_EXP = 4;
`else
    localparam int STALL_EXP = 0;
`endif

    conv_row_sequencer #(
        .KERNEL_SIZE (3),
        .FIFO_SIZE   (10),
        .COL_W       (8),
        .ROW_W       (8),
        .PE_LAT      (1)
    ) dut (
        .clk2         (clk2),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_cols     (cfg_cols),
        .cfg_out_rows (cfg_out_rows),
        .ifm_valid    (ifm_valid),
        .ifm_ready    (ifm_ready),
        .set_ifm      (set_ifm),
        .set_wgt      (set_wgt),
        .fifo_clr     (fifo_clr),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_rd_en   (fifo_rd_en),
        .psum_valid   (psum_valid),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err),
        .stall_cycles (stall_cycles)
    );

    always #5 clk2 = ~clk2;

    // Event counters sampled on the falling edge, away from state updates
    always @(negedge clk2) begin
        if (fifo_clr)   n_clr++;
        if (set_wgt)    n_wgt++;
        if (set_ifm)    n_ifm++;
        if (psum_valid) n_psum++;
        if (done)       n_done++;
        if (busy)       n_busy++;
        for (int i = 0; i < 3; i++) begin
            if (fifo_wr_en[i]) n_wr[i]++;
            if (fifo_rd_en[i]) n_rd[i]++;
        end
        if (prev_rd0 != fifo_wr_en[1]) n_order_err++;
        prev_rd0 = fifo_rd_en[0];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic clear_counts();
        n_clr = 0; n_wgt = 0; n_ifm = 0; n_psum = 0;
        n_done = 0; n_busy = 0; n_order_err = 0;
        prev_rd0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_wr[i] = 0;
            n_rd[i] = 0;
        end
    endtask

    task automatic pulse_start(input int cols, input int rows);
        cfg_cols     = 8'(cols);
        cfg_out_rows = 8'(rows);
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        chk({tag, "_idle_timeout"}, int'(busy), 0);
        tick();
        tick();
    endtask

    task automatic check_job(input string tag, input int cols, input int rows);
        int nw;
        nw = cols - 2;
        chk({tag, "_clr"},   n_clr,  rows);
        chk({tag, "_wgt"},   n_wgt,  rows);
        chk({tag, "_ifm"},   n_ifm,  rows * 3 * cols);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_wr%0d", tag, i), n_wr[i], rows * nw);
            chk($sformatf("%s_rd%0d", tag, i), n_rd[i], rows * nw);
        end
        chk({tag, "_psum"},  n_psum, rows * nw);
        chk({tag, "_done"},  n_done, 1);
        chk({tag, "_order"}, n_order_err, 0);
        chk({tag, "_busy_after"}, int'(busy), 0);
    endtask

    function automatic int out_vec();
        return int'({ifm_ready, set_ifm, set_wgt, fifo_clr, fifo_wr_en, fifo_rd_en,
                     psum_valid, busy, done, cfg_err});
    endfunction

    initial begin
        int g;
        rst_n = 1'b0; start = 1'b0; cfg_cols = '0; cfg_out_rows = '0; ifm_valid = 1'b1;
        clear_counts();
        tick(); tick(); tick();
        chk("reset_outs",  out_vec(), 0);
        chk("reset_stall", int'(stall_cycles), 0);
        rst_n = 1'b1;
        tick();

        // Single output row, 5-pixel rows
        clear_counts();
        pulse_start(5, 1);
        wait_idle("s1");
        check_job("s1", 5, 1);
        chk("s1_stall", int'(stall_cycles), 0);

        // Three output rows in one job
        clear_counts();
        pulse_start(5, 3);
        wait_idle("s2");
        check_job("s2", 5, 3);

        // Row shorter than the kernel
        clear_counts();
        pulse_start(2, 1);
        repeat (5) tick();
        chk("s3_cfg_err", int'(cfg_err), 1);
        chk("s3_busy",    n_busy, 0);
        chk("s3_done",    n_done, 0);
        clear_counts();
        pulse_start(5, 1);
        chk("s3_err_clr", int'(cfg_err), 0);
        wait_idle("s3b");
        check_job("s3b", 5, 1);

        // Eleven windows overflow a 10-deep FIFO
        clear_counts();
        pulse_start(13, 1);
        repeat (5) tick();
        chk("s4_cfg_err", int'(cfg_err), 1);
        chk("s4_busy",    n_busy, 0);
        chk("s4_clr",     n_clr, 0);
        chk("s4_ifm",     n_ifm, 0);

        // Widest legal row: exactly FIFO_SIZE windows
        clear_counts();
        pulse_start(12, 1);
        wait_idle("s5");
        check_job("s5", 12, 1);
        chk("s5_cfg_err", int'(cfg_err), 0);

        // Zero output rows: bare done pulse
        clear_counts();
        pulse_start(5, 0);
        wait_idle("s6");
        chk("s6_done", n_done, 1);
        chk("s6_clr",  n_clr, 0);
        chk("s6_ifm",  n_ifm, 0);
        chk("s6_busy", n_busy, 1);

        // Four-cycle upstream stall in the middle of row 1
        clear_counts();
        pulse_start(5, 1);
        g = 0;
        while (n_ifm < 7 && g < 200) begin
            tick();
            g++;
        end
        chk("s7_reach_row1", int'(n_ifm >= 7), 1);
        ifm_valid = 1'b0;
        repeat (4) tick();
        ifm_valid = 1'b1;
        wait_idle("s7");
        check_job("s7", 5, 1);
        chk("s7_stall", int'(stall_cycles), STALL_EXP);

        // Asynchronous reset while draining
        clear_counts();
        pulse_start(5, 1);
        g = 0;
        while (n_rd[2] < 1 && g < 200) begin
            tick();
            g++;
        end
        chk("s8_reach_drain", int'(n_rd[2] >= 1), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s8_async_outs",  out_vec(), 0);
        chk("s8_async_stall", int'(stall_cycles), 0);
        tick();
        chk("s8_no_done", n_done, 0);
        rst_n = 1'b1;
        tick();
        clear_counts();
        pulse_start(5, 1);
        wait_idle("s8b");
        check_job("s8b", 5, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conv_row_sequencer.md
Name: conv_row_sequencer

Overview:
- Parametrised control sequencer for the row-stationary conv array; replaces hand-driven set_wgt/set_ifm/wr_en_k/rd_en_k/clr stimulus with an FSM.
- Streams KERNEL_SIZE input rows per output row and generates the psum-FIFO write/read enables that chain partial sums row to row.
- Drains the last FIFO as the finished output row.
- Sits between the ifm/wgt fetch logic and TOP; runtime-configurable row length and output row count.

Parameters:
- KERNEL_SIZE, 3, kernel rows/cols; number of psum FIFOs.
- FIFO_SIZE, 10, depth of each psum FIFO; bounds legal cfg_cols.
- COL_W, 8, width of column counter and cfg_cols.
- ROW_W, 8, width of output-row counter and cfg_out_rows.
- PE_LAT, 1, cycles from ifm handshake to PE psum valid; must be >=1.

Ports:
- clk2  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle job start; sampled only in IDLE.
- cfg_cols  in  COL_W  ifm row length in pixels; latched at start.
- cfg_out_rows  in  ROW_W  output rows to produce; latched at start.
- ifm_valid  in  1  upstream pixel available.
- ifm_ready  out  1  sequencer accepts a pixel; handshake = ifm_valid & ifm_ready.
- set_ifm  out  1  PE ifm register load; equals handshake.
- set_wgt  out  1  PE weight load strobe.
- fifo_clr  out  1  clears rd/wr pointers of all psum FIFOs.
- fifo_wr_en  out  KERNEL_SIZE  per-FIFO write enable.
- fifo_rd_en  out  KERNEL_SIZE  per-FIFO read enable.
- psum_valid  out  1  final psum on FIFO K-1 output is valid.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at job end.
- cfg_err  out  1  sticky config error; cleared by the next accepted start.
- stall_cycles  out  16  handshake-stall counter (see Optional Feature).

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0. Async reset mid-job aborts immediately; no drain, no done.
- Definitions: N = cfg_cols-KERNEL_SIZE+1 (windows per row); col = handshake index in current row, 0..cfg_cols-1; k = row within pass, 0..K-1.
- Config check at start: cfg_cols<KERNEL_SIZE or N>FIFO_SIZE -> cfg_err=1, stay IDLE, no done. cfg_out_rows==0 -> done pulse next cycle, no other activity.
- IDLE: on start & legal cfg -> CLEAR.
- CLEAR, 1 cycle: fifo_clr=1 -> LOAD.
- LOAD, 1 cycle: set_wgt=1; k=0, col=0 -> STREAM.
- STREAM: ifm_ready=1. Each handshake increments col.
  - If col>=K-1, write tag fifo_wr_en[k] issues PE_LAT cycles after the handshake.
  - If k>0, read tag fifo_rd_en[k-1] issues PE_LAT-1 cycles after the handshake (1-cycle registered FIFO read aligns with PE input).
  - Tags use a delay line and are independent of later stalls.
  - Handshake at col=cfg_cols-1 -> GAP.
- GAP, 1 cycle, ifm_ready=0:
  - k<K-1: k++, col=0 -> STREAM.
  - else -> FLUSH.
- FLUSH: wait until the delay line is empty (PE_LAT cycles) -> DRAIN.
- DRAIN: fifo_rd_en[K-1]=1 for exactly N consecutive cycles; psum_valid is the rd_en delayed 1 cycle. Then:
  - out_row++.
  - out_row<cfg_out_rows -> CLEAR (next pass; upstream supplies rows shifted by 1, stride 1).
  - else -> DONE.
- DONE, 1 cycle: done=1 -> IDLE.
- start while busy is ignored.
- Each FIFO receives exactly N writes and N reads per pass; it never exceeds N entries, never overflows and never underreads.
- Stall: ifm_valid=0 in STREAM holds col; already-issued tags still drain out.

Optional Feature:
- Macro PERF_CNT_EN.
- Defined: stall_cycles counts cycles in STREAM with ifm_valid=0; saturates at 16'hFFFF; cleared on accepted start.
- Undefined: stall_cycles tied to 0; no counter flops. Port exists in both builds.

Decomposition:
- Shared package conv_ctrl_pkg: state encoding (IDLE, CLEAR, LOAD, STREAM, GAP, FLUSH, DRAIN, DONE) and a localparam for the drain read latency (1).
- One sub-module, en_delay_line: parametrised-depth shift register carrying {wr_tag, rd_tag, k}; instantiated once.
- FSM and counters stay in the top.

Test Plan:
- K=3, PE_LAT=1, cfg_cols=5, cfg_out_rows=1, ifm_valid always 1:
  - fifo_clr and set_wgt each pulse once.
  - 15 set_ifm.
  - fifo_wr_en[0..2] each 3 pulses; fifo_rd_en[0..1] each 3 pulses.
  - DRAIN gives 3 rd_en[2] and 3 psum_valid.
  - done once; busy low after.
- Same config, cfg_out_rows=3: 3 CLEAR/LOAD sequences, 9 psum_valid total, exactly one done.
- cfg_cols=2 -> cfg_err=1, busy stays 0, no done. Then legal start -> cfg_err clears.
- cfg_cols=13 (N=11>FIFO_SIZE=10) -> cfg_err=1, no activity.
- cfg_cols=5, ifm_valid low for 4 cycles mid-row 1:
  - write/read pulse counts identical to scenario 1.
  - each rd_en[0] exactly 1 cycle before the matching wr_en[1].
  - with PERF_CNT_EN, stall_cycles=4.
- rst_n asserted during DRAIN: all outputs 0 asynchronously, state IDLE, no done; next start runs scenario 1 cleanly.
